h_alpha_stream_rx: RTL and testbench

Receive-side framer for the H-row / alpha-column stream pair feeding the case-2 fixed-point core. It samples I beats of `H_row` (J bits each) followed by A beats of `alpha_u_col` (J×8 bits each), checks tvalid/tlast framing, and holds the complete frame in a register bank. It then exposes the frame through a registered read port until the consumer acknowledges it. Streams carry no tready, so the block accepts every valid beat and flags anything it cannot store.

---
 rtl/h_alpha_stream_rx.sv | 191 +++++++++++++++++++
 tb/tb_h_alpha_stream_rx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/h_alpha_stream_rx.sv
// H-row / alpha-column receive framer with frame bank and registered read port.
// Optional: define H_ALPHA_RX_STRICT_TLAST_EN to enforce tlast framing checks.
module h_alpha_stream_rx #(
  parameter int J = 14,
  parameter int I = 7,
  parameter int A = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [J-1:0]         H_row,
  input  logic                 H_row_tvalid,
  input  logic                 H_row_tlast,
  input  logic [J*8-1:0]       alpha_u_col,
  input  logic                 alpha_u_col_tvalid,
  input  logic                 alpha_u_col_tlast,
  output logic                 frame_valid,
  input  logic                 frame_ack,
  input  logic                 rd_en,
  input  logic                 rd_sel,
  input  logic [$clog2(I):0]   rd_addr,
  output logic [J-1:0]         rd_H_row,
  output logic [J*8-1:0]       rd_alpha,
  output logic                 rd_valid,
  output logic                 err_frame,
  output logic                 err_overflow,
  input  logic                 err_clr
);

  localparam int I_WIDTH = $clog2(I) + 1;
  localparam int A_WIDTH = $clog2(A) + 1;
  localparam int HIW = (I > 1) ? $clog2(I) : 1;
  localparam int AIW = (A > 1) ? $clog2(A) : 1;

  localparam logic [I_WIDTH-1:0] H_LAST = I_WIDTH'(I - 1);
  localparam logic [A_WIDTH-1:0] A_LAST = A_WIDTH'(A - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_RX_H     = 3'd1;
  localparam logic [2:0] S_RX_ALPHA = 3'd2;
  localparam logic [2:0] S_READY    = 3'd3;
  localparam logic [2:0] S_ERR      = 3'd4;

  logic [2:0]         r_state;
  logic [I_WIDTH-1:0] r_h_cnt;
  logic [A_WIDTH-1:0] r_a_cnt;
  logic [J-1:0]       r_hbank [I];
  logic [J*8-1:0]     r_abank [A];
  logic               r_err_frame;
  logic               r_err_ovf;
  logic               r_rd_valid;
  logic [J-1:0]       r_rd_h;
  logic [J*8-1:0]     r_rd_a;

  logic [2:0]         w_nxt_state;
  logic [I_WIDTH-1:0] w_h_cnt_nxt;
  logic [A_WIDTH-1:0] w_a_cnt_nxt;
  logic               w_h_we;
  logic               w_a_we;
  logic               w_ovf_set;
  logic               w_err_set;
  logic               w_h_last;
  logic               w_a_last;
  logic               w_h_bad;
  logic               w_a_bad;
  logic               w_rd_h_hit;
  logic               w_rd_a_hit;
  logic [J-1:0]       w_rd_h_data;
  logic [J*8-1:0]     w_rd_a_data;

  assign w_h_last = (r_h_cnt == H_LAST);
  assign w_a_last = (r_a_cnt == A_LAST);

`ifdef H_ALPHA_RX_STRICT_TLAST_EN
  assign w_h_bad = (H_row_tlast != w_h_last);
  assign w_a_bad = (alpha_u_col_tlast != w_a_last);
`else
  logic w_unused_tlast;
  assign w_unused_tlast = H_row_tlast ^ alpha_u_col_tlast;
  assign w_h_bad = 1'b0;
  assign w_a_bad = 1'b0;
`endif

  // IDLE always holds zeroed counters, so it shares the RX_H beat rules
  always_comb begin
    w_nxt_state = r_state;
    w_h_cnt_nxt = r_h_cnt;
    w_a_cnt_nxt = r_a_cnt;
    w_h_we      = 1'b0;
    w_a_we      = 1'b0;
    w_ovf_set   = 1'b0;
    unique case (r_state)
      S_IDLE, S_RX_H: begin
        if (alpha_u_col_tvalid) begin
          w_nxt_state = S_ERR;
        end else if (H_row_tvalid) begin
          w_h_we      = 1'b1;
          w_h_cnt_nxt = r_h_cnt + 1'b1;
          if (w_h_bad)       w_nxt_state = S_ERR;
          else if (w_h_last) w_nxt_state = S_RX_ALPHA;
          else               w_nxt_state = S_RX_H;
        end
      end
      S_RX_ALPHA: begin
        if (H_row_tvalid) begin
          w_nxt_state = S_ERR;
        end else if (alpha_u_col_tvalid) begin
          w_a_we      = 1'b1;
          w_a_cnt_nxt = r_a_cnt + 1'b1;
          if (w_a_bad)       w_nxt_state = S_ERR;
          else if (w_a_last) w_nxt_state = S_READY;
        end
      end
      S_READY: begin
        w_ovf_set = H_row_tvalid | alpha_u_col_tvalid;
        if (frame_ack) begin
          w_nxt_state = S_IDLE;
          w_h_cnt_nxt = '0;
          w_a_cnt_nxt = '0;
        end
      end
      S_ERR: begin
        if (err_clr) begin
          w_nxt_state = S_IDLE;
          w_h_cnt_nxt = '0;
          w_a_cnt_nxt = '0;
        end
      end
      default: begin
        w_nxt_state = S_IDLE;
        w_h_cnt_nxt = '0;
        w_a_cnt_nxt = '0;
      end
    endcase
  end

  assign w_err_set = (w_nxt_state == S_ERR) && (r_state != S_ERR);

  assign w_rd_h_hit  = (32'(rd_addr) < I);
  assign w_rd_a_hit  = (32'(rd_addr) < A);
  assign w_rd_h_data = w_rd_h_hit ? r_hbank[rd_addr[HIW-1:0]] : '0;
  assign w_rd_a_data = w_rd_a_hit ? r_abank[rd_addr[AIW-1:0]] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_h_cnt     <= '0;
      r_a_cnt     <= '0;
      r_err_frame <= 1'b0;
      r_err_ovf   <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_h_cnt <= w_h_cnt_nxt;
      r_a_cnt <= w_a_cnt_nxt;
      // a new error event wins over a same-cycle clear
      if (w_err_set)    r_err_frame <= 1'b1;
      else if (err_clr) r_err_frame <= 1'b0;
      if (w_ovf_set)    r_err_ovf <= 1'b1;
      else if (err_clr) r_err_ovf <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < I; k++) r_hbank[k] <= '0;
      for (int k = 0; k < A; k++) r_abank[k] <= '0;
    end else begin
      if (w_h_we) r_hbank[r_h_cnt[HIW-1:0]] <= H_row;
      if (w_a_we) r_abank[r_a_cnt[AIW-1:0]] <= alpha_u_col;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_valid <= 1'b0;
      r_rd_h     <= '0;
      r_rd_a     <= '0;
    end else begin
      r_rd_valid <= rd_en;
      if (rd_en && !rd_sel) r_rd_h <= w_rd_h_data;
      if (rd_en && rd_sel)  r_rd_a <= w_rd_a_data;
    end
  end

  assign frame_valid  = (r_state == S_READY);
  assign err_frame    = r_err_frame;
  assign err_overflow = r_err_ovf;
  assign rd_valid     = r_rd_valid;
  assign rd_H_row     = r_rd_h;
  assign rd_alpha     = r_rd_a;

endmodule

// File: tb/tb_h_alpha_stream_rx.sv
// Scoreboard bench for h_alpha_stream_rx: directed frames plus random traffic.
// Model tracks a single beat position per frame and a shadow bank.
module tb_h_alpha_stream_rx;
  localparam int J  = 14;
  localparam int I  = 7;
  localparam int A  = 2;
  localparam int AW = $clog2(I) + 1;
  localparam int W  = J * 8;
`ifdef H_ALPHA_RX_STRICT_TLAST_EN
  localparam bit STRICT = 1'b1;
`else
  localparam bit STRICT = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [J-1:0]  H_row;
  logic          H_row_tvalid, H_row_tlast;
  logic [W-1:0]  alpha_u_col;
  logic          alpha_u_col_tvalid, alpha_u_col_tlast;
  logic          frame_valid, frame_ack;
  logic          rd_en, rd_sel;
  logic [AW-1:0] rd_addr;
  logic [J-1:0]  rd_H_row;
  logic [W-1:0]  rd_alpha;
  logic          rd_valid, err_frame, err_overflow, err_clr;

  always #5 clk = ~clk;

  h_alpha_stream_rx #(.J(J), .I(I), .A(A)) dut (
    .clk(clk), .rst_n(rst_n),
    .H_row(H_row), .H_row_tvalid(H_row_tvalid), .H_row_tlast(H_row_tlast),
    .alpha_u_col(alpha_u_col), .alpha_u_col_tvalid(alpha_u_col_tvalid),
    .alpha_u_col_tlast(alpha_u_col_tlast),
    .frame_valid(frame_valid), .frame_ack(frame_ack),
    .rd_en(rd_en), .rd_sel(rd_sel), .rd_addr(rd_addr),
    .rd_H_row(rd_H_row), .rd_alpha(rd_alpha), .rd_valid(rd_valid),
    .err_frame(err_frame), .err_overflow(err_overflow), .err_clr(err_clr)
  );

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [J-1:0] h;
    logic [W-1:0] a;
  } rd_t;
  rd_t q[$];
  rd_t e;

  // reference model: mode 0 collecting, 1 frame held, 2 error
  logic [J-1:0] mh[I];
  logic [W-1:0] ma[A];
  int           mode, n;
  bit           ef, eo, erv;
  logic [J-1:0] mrh;
  logic [W-1:0] mra;

  task automatic chk(input string nm, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < I; k++) mh[k] = '0;
    for (int k = 0; k < A; k++) ma[k] = '0;
    mode = 0; n = 0; ef = 0; eo = 0; erv = 0;
    mrh = '0; mra = '0;
    q.delete();
  endtask

  task automatic idle_inputs();
    H_row = '0; H_row_tvalid = 0; H_row_tlast = 0;
    alpha_u_col = '0; alpha_u_col_tvalid = 0; alpha_u_col_tlast = 0;
    frame_ack = 0; err_clr = 0; rd_en = 0; rd_sel = 0; rd_addr = '0;
  endtask

  task automatic cyc(input bit hv, input logic [J-1:0] hd, input bit htl,
                     input bit av, input logic [W-1:0] ad, input bit atl,
                     input bit ack, input bit clr,
                     input bit ren, input bit rsel, input logic [AW-1:0] ra);
    bit seterr, setovf, expH, last, tl;
    H_row = hd; H_row_tvalid = hv; H_row_tlast = htl;
    alpha_u_col = ad; alpha_u_col_tvalid = av; alpha_u_col_tlast = atl;
    frame_ack = ack; err_clr = clr;
    rd_en = ren; rd_sel = rsel; rd_addr = ra;
    erv = ren;
    if (ren) begin
      if (!rsel) mrh = (int'(ra) < I) ? mh[ra] : '0;
      else       mra = (int'(ra) < A) ? ma[ra] : '0;
      q.push_back('{mrh, mra});
    end
    seterr = 0; setovf = 0;
    if (mode == 1) begin
      setovf = hv | av;
      if (ack) begin mode = 0; n = 0; end
    end else if (mode == 2) begin
      if (clr) begin mode = 0; n = 0; end
    end else begin
      expH = (n < I);
      if ((hv && av) || (hv && !expH) || (av && expH)) begin
        mode = 2; seterr = 1;
      end else if (hv || av) begin
        if (expH) mh[n] = hd; else ma[n-I] = ad;
        last = expH ? (n == I-1) : (n == I+A-1);
        tl = expH ? htl : atl;
        if (STRICT && tl != last) begin
          mode = 2; seterr = 1;
        end else begin
          n++;
          if (n == I+A) mode = 1;
        end
      end
    end
    if (seterr) ef = 1; else if (clr) ef = 0;
    if (setovf) eo = 1; else if (clr) eo = 0;
    @(posedge clk); #1;
    idle_inputs();
    chk("frame_valid", W'(frame_valid), W'(mode == 1));
    chk("err_frame", W'(err_frame), W'(ef));
    chk("err_overflow", W'(err_overflow), W'(eo));
    chk("rd_valid", W'(rd_valid), W'(erv));
  endtask

  task automatic hbeat(input logic [J-1:0] d, input bit tl);
    cyc(1, d, tl, 0, '0, 0, 0, 0, 0, 0, '0);
  endtask
  task automatic abeat(input logic [W-1:0] d, input bit tl);
    cyc(0, '0, 0, 1, d, tl, 0, 0, 0, 0, '0);
  endtask
  task automatic rd(input bit s, input logic [AW-1:0] ad);
    cyc(0, '0, 0, 0, '0, 0, 0, 0, 1, s, ad);
  endtask
  task automatic ctl(input bit ack, input bit clr);
    cyc(0, '0, 0, 0, '0, 0, ack, clr, 0, 0, '0);
  endtask

  function automatic logic [W-1:0] rnd_w();
    return W'({$urandom, $urandom, $urandom, $urandom});
  endfunction

  task automatic full_frame();
    for (int k = 0; k < I; k++) hbeat(J'($urandom), k == I-1);
    for (int k = 0; k < A; k++) abeat(rnd_w(), k == A-1);
  endtask

  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL rd_unexpected got=1 want=0");
      end else begin
        e = q.pop_front();
        chk("rd_H_row", W'(rd_H_row), W'(e.h));
        chk("rd_alpha", rd_alpha, e.a);
      end
    end
  end

  logic [J-1:0] hrows[I];
  bit hv, av, htl, atl, ack, clr;
  int r;

  initial begin
    hrows[0] = 14'b01100010100011; hrows[1] = 14'b00111100001111;
    hrows[2] = 14'b10101010101010; hrows[3] = 14'b11110000111100;
    hrows[4] = 14'b00000011111111; hrows[5] = 14'b10011001100110;
    hrows[6] = 14'b01101001010100;
    rst_n = 0;
    idle_inputs();
    model_reset();
    #12;
    chk("rst_frame_valid", W'(frame_valid), '0);
    chk("rst_rd_valid", W'(rd_valid), '0);
    chk("rst_err_frame", W'(err_frame), '0);
    chk("rst_err_overflow", W'(err_overflow), '0);
    chk("rst_rd_H_row", W'(rd_H_row), '0);
    chk("rst_rd_alpha", rd_alpha, '0);
    @(posedge clk); #1;
    rst_n = 1;

    // nominal frame, zero gap between streams
    for (int k = 0; k < I; k++) hbeat(hrows[k], k == I-1);
    abeat({rnd_w() >> 8, 8'hFF}, 0);
    abeat({rnd_w() >> 8, 8'h01}, 1);
    rd(0, 0);
    rd(1, 1);
    ctl(1, 0);

    // early tlast on row 4
    for (int k = 0; k < I; k++) hbeat(J'($urandom), k == 4);
    ctl(0, 0);
    for (int k = 0; k < A; k++) abeat(rnd_w(), k == A-1);
    ctl(1, 1);
    full_frame();
    rd(0, 3);
    ctl(1, 0);

    // alpha beat while receiving H rows
    for (int k = 0; k < 3; k++) hbeat(J'($urandom), 0);
    abeat(rnd_w(), 0);
    ctl(0, 1);

    // H beat in READY together with ack
    full_frame();
    cyc(1, J'($urandom), 0, 0, '0, 0, 1, 0, 0, 0, '0);
    rd(0, 0);
    ctl(0, 1);

    // reset after three rows
    for (int k = 0; k < 3; k++) hbeat(J'($urandom), 0);
    rst_n = 0;
    #1;
    chk("mid_rst_frame_valid", W'(frame_valid), '0);
    chk("mid_rst_rd_valid", W'(rd_valid), '0);
    chk("mid_rst_rd_H_row", W'(rd_H_row), '0);
    chk("mid_rst_rd_alpha", rd_alpha, '0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1;
    full_frame();
    for (int k = 0; k < I; k++) rd(0, AW'(k));
    rd(1, 0);
    rd(1, 1);
    rd(0, 7);
    rd(1, 2);
    rd(0, 15);
    ctl(1, 0);

    // gap between streams, then random traffic
    for (int k = 0; k < I; k++) hbeat(J'($urandom), k == I-1);
    repeat (4) ctl(0, 0);
    for (int k = 0; k < A; k++) abeat(rnd_w(), k == A-1);
    ctl(1, 0);
    for (int k = 0; k < 3000; k++) begin
      hv = 0; av = 0; htl = 0; atl = 0; ack = 0; clr = 0;
      r = int'($urandom % 100);
      if (mode == 0 && ($urandom % 2) == 1) begin
        if (n < I) begin hv = 1; htl = (n == I-1); end
        else       begin av = 1; atl = (n == I+A-1); end
      end
      if (r < 2) av = 1;
      else if (r < 4) hv = 1;
      else if (r < 7) begin htl = ~htl; atl = ~atl; end
      if (mode == 1 && ($urandom % 3) == 0) ack = 1;
      if (mode == 1 && r >= 90 && r < 93) hv = 1;
      if (mode == 2 && ($urandom % 4) == 0) clr = 1;
      if (r >= 97) clr = 1;
      cyc(hv, J'($urandom), htl, av, rnd_w(), atl, ack, clr,
          bit'($urandom % 2), bit'($urandom % 2), AW'($urandom % 9));
    end
    repeat (3) ctl(0, 0);
    chk("queue_drained", W'(q.size()), '0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
